// File: rtl/regfile_sequencer.sv
// regfile_sequencer: initiator side of the byte-serial register file port.
// Assembles two 32-bit operands from four LSB-first read beats and
// serializes a 32-bit write-back value into four byte write beats.
module regfile_sequencer #(
   parameter int ADDR_W   = 4,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_req,
   output logic              rd_ready,
   input  logic [ADDR_W-1:0] rs1_addr,
   input  logic [ADDR_W-1:0] rs2_addr,
   output logic              op_valid,
   output logic [31:0]       rs1_val,
   output logic [31:0]       rs2_val,
   input  logic              wb_valid,
   output logic              wb_ready,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [31:0]       wb_data,
   output logic [1:0]        rf_phase,
   output logic [ADDR_W-1:0] rf_rs1,
   output logic [ADDR_W-1:0] rf_rs2,
   output logic [ADDR_W-1:0] rf_rd,
   input  logic [7:0]        rf_rs1_dat,
   input  logic [7:0]        rf_rs2_dat,
   output logic [7:0]        rf_rd_dat,
   output logic              rf_we,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2
   } state_t;

   state_t            r_state;
   logic [1:0]        r_ph;
   logic [ADDR_W-1:0] r_rs1_a;
   logic [ADDR_W-1:0] r_rs2_a;
   logic [ADDR_W-1:0] r_rd_a;
   logic [31:0]       r_wdata;
   logic [23:0]       r_sh1;
   logic [23:0]       r_sh2;
   logic [31:0]       r_rs1_val;
   logic [31:0]       r_rs2_val;
   logic              r_op_valid;

   logic              w_rs1_zero;
   logic              w_rs2_zero;
   logic              w_rd_zero;
   logic [7:0]        w_b1;
   logic [7:0]        w_b2;
   logic              w_active;

   // Register 0 is hard-wired to zero when ZERO_REG is set: reads mask, writes drop.
   assign w_rs1_zero = ZERO_REG && (r_rs1_a == '0);
   assign w_rs2_zero = ZERO_REG && (r_rs2_a == '0);
   assign w_rd_zero  = ZERO_REG && (r_rd_a == '0);
   assign w_b1       = w_rs1_zero ? 8'h00 : rf_rs1_dat;
   assign w_b2       = w_rs2_zero ? 8'h00 : rf_rs2_dat;
   assign w_active   = (r_state == READ) || (r_state == WRITE);

   // Write-back wins over read in IDLE so a following read sees the new value.
   assign wb_ready  = (r_state == IDLE);
   assign rd_ready  = (r_state == IDLE) && !wb_valid;
   assign busy      = (r_state != IDLE);

   assign rf_phase  = w_active ? r_ph : 2'd0;
   assign rf_rs1    = r_rs1_a;
   assign rf_rs2    = r_rs2_a;
   assign rf_rd     = r_rd_a;
   assign rf_we     = (r_state == WRITE) && !w_rd_zero;
   assign rf_rd_dat = (r_state == WRITE) ? r_wdata[{r_ph, 3'b000} +: 8] : 8'h00;

   assign op_valid  = r_op_valid;
   assign rs1_val   = r_rs1_val;
   assign rs2_val   = r_rs2_val;

   // Sequencer FSM: handshake in IDLE, then four phase beats of READ or WRITE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_ph       <= 2'd0;
         r_rs1_a    <= '0;
         r_rs2_a    <= '0;
         r_rd_a     <= '0;
         r_wdata    <= 32'h0;
         r_sh1      <= 24'h0;
         r_sh2      <= 24'h0;
         r_rs1_val  <= 32'h0;
         r_rs2_val  <= 32'h0;
         r_op_valid <= 1'b0;
      end else begin
         r_op_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               r_ph <= 2'd0;
               if (wb_valid) begin
                  r_rd_a  <= wb_addr;
                  r_wdata <= wb_data;
                  r_state <= WRITE;
               end else if (rd_req) begin
                  r_rs1_a <= rs1_addr;
                  r_rs2_a <= rs2_addr;
                  r_state <= READ;
               end
            end
            READ: begin
               r_ph <= r_ph + 2'd1;
               case (r_ph)
                  2'd0: begin
                     r_sh1[7:0] <= w_b1;
                     r_sh2[7:0] <= w_b2;
                  end
                  2'd1: begin
                     r_sh1[15:8] <= w_b1;
                     r_sh2[15:8] <= w_b2;
                  end
                  2'd2: begin
                     r_sh1[23:16] <= w_b1;
                     r_sh2[23:16] <= w_b2;
                  end
                  default: begin
                     // Last beat: publish both full words at once.
                     r_rs1_val  <= {w_b1, r_sh1};
                     r_rs2_val  <= {w_b2, r_sh2};
                     r_op_valid <= 1'b1;
                     r_state    <= IDLE;
                  end
               endcase
            end
            WRITE: begin
               r_ph <= r_ph + 2'd1;
               if (r_ph == 2'd3) begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_ph    <= 2'd0;
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer with a behavioural 16x32 register
// file and a scoreboard queue of expected operand pairs.
module tb_regfile_sequencer;

   localparam int ADDR_W = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              rd_req;
   logic              rd_ready;
   logic [ADDR_W-1:0] rs1_addr;
   logic [ADDR_W-1:0] rs2_addr;
   logic              op_valid;
   logic [31:0]       rs1_val;
   logic [31:0]       rs2_val;
   logic              wb_valid;
   logic              wb_ready;
   logic [ADDR_W-1:0] wb_addr;
   logic [31:0]       wb_data;
   logic [1:0]        rf_phase;
   logic [ADDR_W-1:0] rf_rs1;
   logic [ADDR_W-1:0] rf_rs2;
   logic [ADDR_W-1:0] rf_rd;
   logic [7:0]        rf_rs1_dat;
   logic [7:0]        rf_rs2_dat;
   logic [7:0]        rf_rd_dat;
   logic              rf_we;
   logic              busy;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [16];
   logic [31:0] ref_regs [16];
   logic        mem_clr;
   logic        aa;
   logic [63:0] expq [$];
   logic [63:0] mon_e;
   logic [31:0] hold1;
   logic [31:0] hold2;

   always #5 clk = ~clk;

   regfile_sequencer #(.ADDR_W(ADDR_W), .ZERO_REG(1'b1)) dut (
      .clk(clk), .rst(rst),
      .rd_req(rd_req), .rd_ready(rd_ready),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .op_valid(op_valid), .rs1_val(rs1_val), .rs2_val(rs2_val),
      .wb_valid(wb_valid), .wb_ready(wb_ready),
      .wb_addr(wb_addr), .wb_data(wb_data),
      .rf_phase(rf_phase), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd(rf_rd),
      .rf_rs1_dat(rf_rs1_dat), .rf_rs2_dat(rf_rs2_dat),
      .rf_rd_dat(rf_rd_dat), .rf_we(rf_we), .busy(busy)
   );

   // Behavioural byte-serial register file
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      end else if (rf_we) begin
         mem[rf_rd][{rf_phase, 3'b000} +: 8] <= rf_rd_dat;
      end
   end

   assign rf_rs1_dat = aa ? 8'hAA : mem[rf_rs1][{rf_phase, 3'b000} +: 8];
   assign rf_rs2_dat = aa ? 8'hAA : mem[rf_rs2][{rf_phase, 3'b000} +: 8];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_rd(input logic [3:0] a);
      if (a == 4'd0) return 32'h0;
      else if (aa) return 32'hAAAAAAAA;
      else return ref_regs[a];
   endfunction

   // Scoreboard: every op_valid pulse consumes one expected operand pair
   always @(negedge clk) begin
      if (!rst && op_valid) begin
         if (expq.size() == 0) begin
            chk("op_valid_unexpected", 32'd1, 32'd0);
         end else begin
            mon_e = expq.pop_front();
            chk("rs1_val", rs1_val, mon_e[63:32]);
            chk("rs2_val", rs2_val, mon_e[31:0]);
         end
      end
   end

   task automatic do_write(input logic [3:0] a, input logic [31:0] d);
      @(negedge clk);
      wb_valid = 1'b1; wb_addr = a; wb_data = d;
      #1;
      chk("wb_ready", wb_ready, 32'd1);
      chk("rd_ready_during_wb", rd_ready, 32'd0);
      if (a != 4'd0) ref_regs[a] = d;
      @(posedge clk);
      #1 wb_valid = 1'b0; wb_addr = 4'hF; wb_data = 32'h0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("wr_busy", busy, 32'd1);
         chk("wr_rf_we", rf_we, (a != 4'd0) ? 32'd1 : 32'd0);
         chk("wr_phase", rf_phase, c);
         chk("wr_rf_rd", rf_rd, a);
         if (a != 4'd0) chk("wr_byte", rf_rd_dat, (d >> (8 * c)) & 32'hFF);
      end
      @(negedge clk);
      chk("wr_done_busy", busy, 32'd0);
      chk("wr_done_we", rf_we, 32'd0);
   endtask

   task automatic do_read(input logic [3:0] a1, input logic [3:0] a2);
      logic [31:0] e1, e2;
      @(negedge clk);
      rd_req = 1'b1; rs1_addr = a1; rs2_addr = a2;
      #1;
      chk("rd_ready", rd_ready, 32'd1);
      e1 = exp_rd(a1);
      e2 = exp_rd(a2);
      expq.push_back({e1, e2});
      @(posedge clk);
      #1 rd_req = 1'b0; rs1_addr = 4'hF; rs2_addr = 4'hF;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("rd_phase", rf_phase, c);
         chk("rd_rf_rs1", rf_rs1, a1);
         chk("rd_rf_rs2", rf_rs2, a2);
         chk("rd_we_low", rf_we, 32'd0);
         chk("rd_op_valid_early", op_valid, 32'd0);
         chk("rs1_hold", rs1_val, hold1);
         chk("rs2_hold", rs2_val, hold2);
      end
      @(negedge clk);
      chk("op_valid_cycle5", op_valid, 32'd1);
      @(negedge clk);
      chk("op_valid_pulse", op_valid, 32'd0);
      hold1 = e1;
      hold2 = e2;
   endtask

   initial begin
      rst = 1'b1; mem_clr = 1'b1; aa = 1'b0;
      rd_req = 1'b0; wb_valid = 1'b0;
      rs1_addr = '0; rs2_addr = '0; wb_addr = '0; wb_data = 32'h0;
      hold1 = 32'h0; hold2 = 32'h0;
      for (int i = 0; i < 16; i++) ref_regs[i] = 32'h0;

      // Reset and idle
      repeat (2) @(posedge clk);
      mem_clr = 1'b0;
      #1;
      chk("rst_we", rf_we, 32'd0);
      chk("rst_op_valid", op_valid, 32'd0);
      chk("rst_busy", busy, 32'd0);
      chk("rst_phase", rf_phase, 32'd0);
      chk("rst_rs1_val", rs1_val, 32'd0);
      chk("rst_rf_rd_dat", rf_rd_dat, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("idle_rd_ready", rd_ready, 32'd1);
      chk("idle_wb_ready", wb_ready, 32'd1);

      // Write then read back
      do_write(4'd5, 32'hDEADBEEF);
      do_read(4'd5, 4'd5);

      // Dual operand
      do_write(4'd3, 32'h01234567);
      do_write(4'd9, 32'h89ABCDEF);
      do_read(4'd3, 4'd9);

      // Priority: write and read requested together
      @(negedge clk);
      wb_valid = 1'b1; wb_addr = 4'd3; wb_data = 32'hCAFEF00D;
      rd_req = 1'b1; rs1_addr = 4'd3; rs2_addr = 4'd9;
      #1;
      chk("prio_wb_ready", wb_ready, 32'd1);
      chk("prio_rd_ready", rd_ready, 32'd0);
      ref_regs[3] = 32'hCAFEF00D;
      @(posedge clk);
      #1 wb_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("prio_wr_we", rf_we, 32'd1);
         chk("prio_rd_blocked", rd_ready, 32'd0);
      end
      @(negedge clk);
      chk("prio_rd_ready_after", rd_ready, 32'd1);
      expq.push_back({32'hCAFEF00D, 32'h89ABCDEF});
      @(posedge clk);
      #1 rd_req = 1'b0;
      repeat (4) @(negedge clk);
      @(negedge clk);
      chk("prio_op_valid", op_valid, 32'd1);
      hold1 = 32'hCAFEF00D; hold2 = 32'h89ABCDEF;

      // Register 0: writes dropped, reads forced to zero
      do_write(4'd0, 32'hFFFFFFFF);
      aa = 1'b1;
      do_read(4'd0, 4'd3);
      aa = 1'b0;

      // Abort a read in phase 2
      @(negedge clk);
      rd_req = 1'b1; rs1_addr = 4'd5; rs2_addr = 4'd9;
      @(posedge clk);
      #1 rd_req = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_rd_phase", rf_phase, 32'd2);
      #2 rst = 1'b1;
      #1;
      chk("abort_rd_busy", busy, 32'd0);
      chk("abort_rd_op_valid", op_valid, 32'd0);
      chk("abort_rd_rs1_val", rs1_val, 32'd0);
      chk("abort_rd_rs2_val", rs2_val, 32'd0);
      chk("abort_rd_phase0", rf_phase, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      hold1 = 32'h0; hold2 = 32'h0;
      repeat (6) @(negedge clk);
      chk("abort_rd_no_op_valid", op_valid, 32'd0);

      // Abort a write in phase 1
      @(negedge clk);
      wb_valid = 1'b1; wb_addr = 4'd7; wb_data = 32'h11223344;
      @(posedge clk);
      #1 wb_valid = 1'b0;
      @(negedge clk);
      chk("abort_wr_we_ph0", rf_we, 32'd1);
      @(negedge clk);
      chk("abort_wr_ph1", rf_phase, 32'd1);
      chk("abort_wr_we_ph1", rf_we, 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("abort_wr_we_drop", rf_we, 32'd0);
      chk("abort_wr_busy", busy, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_wr_partial", mem[7], 32'h00000044);
      ref_regs[7] = 32'h00000044;
      do_read(4'd7, 4'd5);

      repeat (2) @(negedge clk);
      chk("scoreboard_drained", expq.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_sequencer.md
Name: regfile_sequencer

Overview:
- Initiator side of the byte-serial register file port.
- Accepts 32-bit operand-read and write-back requests from the core.
- Drives the 2-bit phase counter and the register addresses; assembles two 32-bit operands from four 8-bit read beats; serializes a 32-bit result into four 8-bit write beats.
- Sits between the core datapath and register_file.

Parameters:
- ADDR_W, 4, register address width (16 registers).
- ZERO_REG, 1, when 1, register 0 reads as zero and writes to it are dropped.

Ports:
- clk  in  1  clock, all state changes on rising edge
- rst  in  1  asynchronous active-high reset
- rd_req  in  1  core requests operand read
- rd_ready  out  1  read request accepted this cycle when rd_req also high
- rs1_addr  in  ADDR_W  operand 1 register
- rs2_addr  in  ADDR_W  operand 2 register
- op_valid  out  1  one-cycle pulse: rs1_val/rs2_val complete
- rs1_val  out  32  assembled operand 1
- rs2_val  out  32  assembled operand 2
- wb_valid  in  1  core requests write-back
- wb_ready  out  1  write-back accepted this cycle when wb_valid also high
- wb_addr  in  ADDR_W  destination register
- wb_data  in  32  write-back value
- rf_phase  out  2  phase to register file (byte select)
- rf_rs1  out  ADDR_W  read address 1 to register file
- rf_rs2  out  ADDR_W  read address 2 to register file
- rf_rd  out  ADDR_W  write address to register file
- rf_rs1_dat  in  8  read byte 1 from register file (combinational for current phase/address)
- rf_rs2_dat  in  8  read byte 2 from register file
- rf_rd_dat  out  8  write byte to register file
- rf_we  out  1  write strobe; register file writes byte rf_phase at clock edge
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, READ, WRITE. Phase counter ph[1:0] runs 0,1,2,3 within READ/WRITE. Phase p carries bits [8p+7:8p] (LSB first).
- Reset (asynchronous, immediate):
  - state=IDLE, ph=0, op_valid=0, rs1_val=rs2_val=0, rf_we=0, rf_rd_dat=0.
  - Address regs=0, so rf_rs1=rf_rs2=rf_rd=0 and rf_phase=0.
- IDLE:
  - wb_ready=1; rd_ready = !wb_valid. Write has priority so reads issued after a write-back observe it.
  - wb_valid handshake: latch wb_addr/wb_data, go to WRITE with ph=0.
  - Else rd_req handshake: latch rs1_addr/rs2_addr, go to READ with ph=0.
- READ, 4 cycles:
  - rf_phase=ph, rf_rs1/rf_rs2 = latched addresses, rf_we=0.
  - At each edge, capture rf_rs1_dat/rf_rs2_dat into byte ph of the shadow operands; ph increments.
  - At the edge where ph=3: update rs1_val/rs2_val from the full words, set op_valid=1, return to IDLE, ph wraps to 0.
  - ZERO_REG=1 with latched address 0: that operand's bytes are forced to 0 regardless of rf_*_dat.
- WRITE, 4 cycles:
  - rf_phase=ph, rf_rd=latched address, rf_rd_dat=byte ph of latched data, rf_we=1.
  - Exception: rf_we=0 throughout when ZERO_REG=1 and address is 0. The cycle count is unchanged.
  - After the ph=3 edge, return to IDLE.
- Outputs outside READ/WRITE: rf_we=0, rf_rd_dat=0, rf_phase=0.
- Latency (handshake in cycle 0):
  - Read: phases in cycles 1–4, op_valid high in cycle 5 only.
  - Write: rf_we high cycles 1–4.
  - A new handshake may occur in cycle 5, the same cycle as op_valid.
- rs1_val/rs2_val hold their values until the next read completes; they do not change during a later READ.
- Address and data inputs are don't-care except in the handshake cycle.
- Simultaneous wb_valid and rd_req in IDLE: write accepted, rd_ready=0; read is accepted in the first IDLE cycle after the write, if still asserted.
- Reset mid-operation: operation aborts; no op_valid. A partially written register (bytes 0..ph-1 updated) is permitted and is the caller's concern.
- No back-pressure on op_valid; the core must take it.

Test Plan:
- Reset then idle: rst high async mid-cycle -> rf_we=0, op_valid=0, busy=0, rf_phase=0 immediately; after release, rd_ready=1, wb_ready=1.
- Write then read back: wb_addr=5, wb_data=0xDEADBEEF -> cycles 1–4 rf_we=1, rf_phase 0..3, rf_rd_dat EF,BE,AD,DE. Then read rs1=5, rs2=5 from a behavioural 16x32 register file model -> op_valid in cycle 5, rs1_val=rs2_val=0xDEADBEEF.
- Dual operand: regs 3=0x01234567, 9=0x89ABCDEF; read rs1=3, rs2=9 -> rs1_val=0x01234567, rs2_val=0x89ABCDEF; op_valid exactly one cycle.
- Priority: wb_valid and rd_req both high in IDLE -> wb_ready=1, rd_ready=0; WRITE runs 4 cycles; read accepted in next IDLE cycle and returns the newly written value.
- Register 0: write 0xFFFFFFFF to addr 0 -> rf_we stays 0 for 4 busy cycles; read rs1=0 with model driving 0xAA bytes -> rs1_val=0.
- Abort: assert rst during READ phase 2 -> no op_valid, rs1_val=0. Assert rst during WRITE phase 1 -> rf_we drops same cycle; only byte 0 written in model.
